// File: rtl/serial_frame_sender.sv
// serial_frame_sender: parallel-to-serial frame generator for the length-prefixed link.
// Frame on serOut: start bit (0), length field MSB first, payload MSB first, stop bit (1).
module serial_frame_sender #(
  parameter int LEN_W  = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic [LEN_W-1:0]  len_in,
  output logic              serOut,
  output logic              ready,
  output logic              frame_valid,
  output logic              done,
  output logic [LEN_W:0]    downcounter
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    LEN,
    DATA,
    STOP
  } state_t;

  localparam logic [LEN_W:0]   CNT_ONE = (LEN_W+1)'(1);
  localparam logic [LEN_W-1:0] IDX_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] IDX_TOP = LEN_W'(LEN_W - 1);

  state_t            state;
  state_t            stateNext;
  logic [DATA_W-1:0] dataReg;
  logic [LEN_W-1:0]  lenReg;
  logic [LEN_W-1:0]  idx;
  logic [LEN_W:0]    cnt;
  logic [LEN_W-1:0]  bitPos;

  // A count of 2**LEN_W wraps to index DATA_W-1 in LEN_W bits, so the
  // truncated subtraction addresses the whole payload without a wider index.
  assign bitPos      = cnt[LEN_W-1:0] - IDX_ONE;
  assign downcounter = cnt;

  // State register; reset drops any frame in flight straight back to idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and output decode; outputs depend only on registered state.
  always_comb begin
    stateNext   = state;
    serOut      = 1'b1;
    ready       = 1'b0;
    frame_valid = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (load) begin
          stateNext = START;
        end
      end
      START: begin
        serOut    = 1'b0;
        stateNext = LEN;
      end
      LEN: begin
        serOut      = lenReg[idx];
        frame_valid = 1'b1;
        if (idx == '0) begin
          stateNext = DATA;
        end
      end
      DATA: begin
        serOut      = dataReg[bitPos];
        frame_valid = 1'b1;
        if (cnt == CNT_ONE) begin
          stateNext = STOP;
        end
      end
      STOP: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Frame datapath: capture the request on acceptance, then walk the length
  // field index and the payload countdown; inputs are ignored once latched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dataReg <= '0;
      lenReg  <= '0;
      idx     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            dataReg <= data_in;
            lenReg  <= len_in;
          end
          cnt <= '0;
        end
        START: begin
          idx <= IDX_TOP;
        end
        LEN: begin
          if (idx == '0) begin
            cnt <= {1'b0, lenReg} + CNT_ONE;
          end else begin
            idx <= idx - IDX_ONE;
          end
        end
        DATA: begin
          cnt <= cnt - CNT_ONE;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
